// File: rtl/bexkat1Def.sv
// Shared definitions for the bexkat1 pipeline control blocks: stall FSM
// state encoding and the default exception drain length.
package bexkat1Def;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } stall_state_t;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/stall_perf.sv
// Stall and flush performance counters; free-running, wrap at 2^32.
module stall_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_id,
  input  logic        flush_id,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_id) stall_cycles <= stall_cycles + 32'd1;
      if (flush_id) flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard / stall controller: load-use, multi-cycle EXE, branch flush,
// exception drain. Define STALL_CTRL_PERF_EN to build the performance counters.
module stall_ctrl
  import bexkat1Def::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] id_ir,
  input  logic [63:0] exe_ir,
  input  logic        exe_mem_read,
  input  logic        exe_multi,
  input  logic        exe_done,
  input  logic        exe_branch,
  input  logic        mem_wait,
  input  logic        exc_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_exe,
  output logic        stall_mem,
  output logic        bubble_exe,
  output logic        flush_if,
  output logic        flush_id,
  output logic        exc_ack,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  stall_state_t  state_reg, state_next;
  logic [CW-1:0] drain_cnt_reg, drain_cnt_next;

  logic [3:0] id_rb, id_rc, exe_ra;
  logic       load_use;
  logic       unused_ir_bits;

  assign id_rb  = id_ir[19:16];
  assign id_rc  = id_ir[15:12];
  assign exe_ra = exe_ir[23:20];
  assign unused_ir_bits = ^{id_ir[63:20], id_ir[11:0], exe_ir[63:24], exe_ir[19:0]};

  // Register fields are compared whatever the ID opcode; a false stall is harmless.
  assign load_use = exe_mem_read && ((exe_ra == id_rb) || (exe_ra == id_rc));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_exe      = 1'b0;
    stall_mem      = 1'b0;
    bubble_exe     = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    exc_ack        = 1'b0;

    if (mem_wait) begin
      // Bus wait freezes the whole pipe and the FSM, whatever state we are in.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_mem = 1'b1;
    end else begin
      case (state_reg)
        ST_DRAIN: begin
          stall_if = 1'b1;
          flush_id = 1'b1;
          if (drain_cnt_reg == '0) state_next = ST_ACK;
          else drain_cnt_next = drain_cnt_reg - 1'b1;
        end
        ST_ACK: begin
          exc_ack    = 1'b1;
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          state_next = ST_RUN;
        end
        ST_MULTI: begin
          if (exe_done) begin
            if (exc_req) begin
              state_next     = ST_DRAIN;
              drain_cnt_next = DRAIN_LOAD;
            end else begin
              state_next = ST_RUN;
            end
          end else begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_exe = 1'b1;
          end
        end
        default: begin
          if (exe_branch) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
          end else if (exe_multi && !exe_done) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_exe  = 1'b1;
            state_next = ST_MULTI;
          end else if (load_use) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            bubble_exe = 1'b1;
          end
          // A pending multi-cycle op completes before the exception is taken.
          if (exc_req && (state_next == ST_RUN)) begin
            state_next     = ST_DRAIN;
            drain_cnt_next = DRAIN_LOAD;
          end
        end
      endcase
    end

    if (rst_i) begin
      stall_if   = mem_wait;
      stall_id   = mem_wait;
      stall_exe  = mem_wait;
      stall_mem  = mem_wait;
      bubble_exe = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      exc_ack    = 1'b0;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  stall_perf u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl; output vector order is
// {stall_if, stall_id, stall_exe, stall_mem, bubble_exe, flush_if, flush_id, exc_ack}.
module tb_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] id_ir, exe_ir;
  logic        exe_mem_read, exe_multi, exe_done, exe_branch, mem_wait, exc_req;
  logic        stall_if, stall_id, stall_exe, stall_mem, bubble_exe, flush_if, flush_id, exc_ack;
  logic [31:0] stall_cycles, flush_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  stall_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_ir        (id_ir),
    .exe_ir       (exe_ir),
    .exe_mem_read (exe_mem_read),
    .exe_multi    (exe_multi),
    .exe_done     (exe_done),
    .exe_branch   (exe_branch),
    .mem_wait     (mem_wait),
    .exc_req      (exc_req),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_exe    (stall_exe),
    .stall_mem    (stall_mem),
    .bubble_exe   (bubble_exe),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .exc_ack      (exc_ack),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] outs();
    return {stall_if, stall_id, stall_exe, stall_mem, bubble_exe, flush_if, flush_id, exc_ack};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, mu, dn, br, mw, ex,
                       input logic [3:0] ra, rb, rc);
    exe_mem_read = mr; exe_multi = mu; exe_done = dn;
    exe_branch = br; mem_wait = mw; exc_req = ex;
    id_ir = 64'hFFFF_FFFF_FFFF_FFFF;
    id_ir[19:16] = rb;
    id_ir[15:12] = rc;
    exe_ir = 64'h0;
    exe_ir[23:20] = ra;
  endtask

  // Entered 1 time unit after a rising edge; checks outputs mid-cycle,
  // then counters just after the following edge.
  task automatic step(input string tag, input logic mr, mu, dn, br, mw, ex,
                      input logic [3:0] ra, rb, rc, input logic [7:0] exp);
    drive(mr, mu, dn, br, mw, ex, ra, rb, rc);
    #3;
    chk(tag, {24'h0, outs()}, {24'h0, exp});
`ifdef STALL_CTRL_PERF_EN
    exp_sc = exp_sc + {31'h0, exp[6]};
    exp_fc = exp_fc + {31'h0, exp[1]};
`endif
    @(posedge clk_i); #1;
    chk({tag, "_sc"}, stall_cycles, exp_sc);
    chk({tag, "_fc"}, flush_count, exp_fc);
    $display("step %-10s outs=%b exp=%b sc=%0d fc=%0d", tag, outs(), exp, stall_cycles, flush_count);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0);
    #2;
    chk("rst_mw", {24'h0, outs()}, 32'h0000_00F0);
    chk("rst_sc", stall_cycles, 32'h0);
    chk("rst_fc", flush_count, 32'h0);
    drive(1, 1, 0, 1, 0, 1, 4'h3, 4'h3, 4'h3);
    #1;
    chk("rst_quiet", {24'h0, outs()}, 32'h0);
    @(posedge clk_i); #1;
    chk("rst_hold", {24'h0, outs()}, 32'h0);
    rst_i = 1'b0;

    //    tag          mr mu dn br mw ex  ra    rb    rc    expected
    step("idle0",       0, 0, 0, 0, 0, 0, 4'h3, 4'h3, 4'h3, 8'b0000_0000);
    step("lu_rb",       1, 0, 0, 0, 0, 0, 4'h3, 4'h3, 4'h7, 8'b1100_1000);
    step("lu_rb_off",   0, 0, 0, 0, 0, 0, 4'h3, 4'h3, 4'h7, 8'b0000_0000);
    step("lu_rc",       1, 0, 0, 0, 0, 0, 4'h3, 4'h1, 4'h3, 8'b1100_1000);
    step("lu_miss",     1, 0, 0, 0, 0, 0, 4'h4, 4'h3, 4'h3, 8'b0000_0000);
    step("br_lu",       1, 0, 0, 1, 0, 0, 4'h3, 4'h3, 4'h3, 8'b0000_0110);
    step("mul_start",   0, 1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mul_w1",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mul_w2",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mul_w3",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mul_w4",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mul_done",    0, 0, 1, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("run_a",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("mul_fast",    0, 1, 1, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("run_b",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("mw_run",      1, 0, 0, 1, 1, 0, 4'h3, 4'h3, 4'h3, 8'b1111_0000);
    step("exc_run",     0, 0, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("drn_a1",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_mw",      0, 0, 0, 0, 1, 0, 4'h0, 4'h1, 4'h2, 8'b1111_0000);
    step("drn_a2_br",   0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_a3",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("ack_a",       0, 0, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b0000_0111);
    step("run_c",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("exc_b",       0, 0, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("drn_b1",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_b2",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_b3",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("ack_b",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0111);
    step("run_d",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("mx_start",    0, 1, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mx_mw",       0, 0, 0, 0, 1, 1, 4'h0, 4'h1, 4'h2, 8'b1111_0000);
    step("mx_wait",     0, 0, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b1110_0000);
    step("mx_done",     0, 0, 1, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("drn_c1",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_c2",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("drn_c3",      0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1000_0010);
    step("ack_c",       0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0111);
    step("mr_start",    0, 1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b1110_0000);

    // Asynchronous reset while sitting in MULTI.
    drive(0, 0, 0, 0, 0, 1, 4'h0, 4'h1, 4'h2);
    #1;
    rst_i = 1'b1;
    #1;
    exp_sc = '0;
    exp_fc = '0;
    chk("arst_outs", {24'h0, outs()}, 32'h0);
    chk("arst_sc", stall_cycles, exp_sc);
    chk("arst_fc", flush_count, exp_fc);
    $display("step %-10s outs=%b sc=%0d fc=%0d", "arst", outs(), stall_cycles, flush_count);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step("post_rst",    0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h2, 8'b0000_0000);
    step("post_lu",     1, 0, 0, 0, 0, 0, 4'h5, 4'h5, 4'h2, 8'b1100_1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL have a parameter DRAIN_CYCLES, default 3, giving the number of drain cycles before exception acknowledge.
REQ-002 clk_i  in  1  single clock, all state rising-edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 id_ir  in  64  ID-stage instruction word; rb at [19:16], rc at [15:12].
REQ-005 exe_ir  in  64  EXE-stage instruction word; ra at [23:20].
REQ-006 exe_mem_read  in  1  EXE instruction is a load.
REQ-007 exe_multi  in  1  EXE instruction is a multi-cycle op; valid first EXE cycle.
REQ-008 exe_done  in  1  multi-cycle unit result ready.
REQ-009 exe_branch  in  1  branch/jump taken, resolved in EXE.
REQ-010 mem_wait  in  1  bus not ready for MEM-stage access.
REQ-011 exc_req  in  1  exception/interrupt request, level.
REQ-012 stall_if, stall_id, stall_exe, stall_mem  out  1 each  hold stage register.
REQ-013 bubble_exe  out  1  load NOP into EXE at next edge.
REQ-014 flush_if, flush_id  out  1 each  replace stage contents with NOP.
REQ-015 exc_ack  out  1  one-cycle pulse, pipeline drained.
REQ-016 stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-017 States SHALL be RUN, MULTI, DRAIN, ACK; outputs combinational from state and inputs.
REQ-018 Priority SHALL be: mem_wait > DRAIN/ACK > exe_branch > MULTI/exe_multi > load-use.
REQ-019 mem_wait=1 SHALL assert all four stall_* and no flush/bubble, in every state; state, drain counter and multi-cycle wait frozen.
REQ-020 Load-use: exe_mem_read=1 and exe_ra equal to id rb or id rc SHALL assert stall_if, stall_id, bubble_exe for exactly that cycle; no state change; rb/rc compared regardless of ID opcode.
REQ-021 exe_branch=1 in RUN SHALL assert flush_if, flush_id that cycle and suppress load-use stall.
REQ-022 RUN, exe_multi=1, exe_done=0 -> MULTI; stall_if, stall_id, stall_exe asserted in that cycle and throughout MULTI.
REQ-023 MULTI, exe_done=1 -> RUN; stalls deasserted that cycle; exe_multi with exe_done=1 same cycle stays RUN, no stall.
REQ-024 exc_req=1 in RUN or MULTI (after exe_done) -> DRAIN, counter loaded with DRAIN_CYCLES-1.
REQ-025 DRAIN SHALL assert stall_if and flush_id each cycle; counter decrements; at 0 -> ACK.
REQ-026 ACK SHALL assert exc_ack and flush_if, flush_id for one cycle, then RUN regardless of exc_req.
REQ-027 exe_branch during DRAIN SHALL be ignored (drain already flushes).

Reset
REQ-028 rst_i SHALL force state RUN, drain counter 0, counters 0 immediately, mid-operation included.
REQ-029 During reset all outputs SHALL be 0 except stall_* which follow mem_wait.

Configuration
REQ-030 With STALL_CTRL_PERF_EN defined, stall_cycles SHALL increment each cycle stall_id=1 and flush_count each cycle flush_id=1, both wrapping at 2^32.
REQ-031 Without STALL_CTRL_PERF_EN, stall_cycles and flush_count SHALL be constant 0 and no counter flops synthesised.

Structure
REQ-032 State enum typedef and DRAIN_CYCLES default constant SHALL live in package bexkat1Def.
REQ-033 The counters SHALL be one sub-module stall_perf, instantiated only under STALL_CTRL_PERF_EN.

Verification
REQ-034 exe_mem_read=1, exe_ra=3, id rb=3 one cycle -> stall_if=stall_id=bubble_exe=1 that cycle only; rc=3 likewise; ra=4 -> no stall.
REQ-035 exe_multi=1, exe_done after 5 cycles -> stall_exe high 5 cycles, RUN on 6th, stall_cycles +5.
REQ-036 exe_branch=1 with simultaneous load-use -> flush_if=flush_id=1, bubble_exe=0, flush_count +1.
REQ-037 exc_req=1 in RUN, DRAIN_CYCLES=3 -> 3 DRAIN cycles, exc_ack pulse on 4th, then RUN; mem_wait=1 during DRAIN extends drain one cycle per wait cycle.
REQ-038 rst_i asserted in MULTI -> RUN asynchronously, counters 0, no exc_ack.
